pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Game-level sequencer for the paddle/ball playfield datapath. Runs the match state machine (idle, serve delay, play, miss pause, game over) and tells the playfield when to freeze, reload or run the ball. Owns score, lives and high-score bookkeeping from one-cycle hit/miss event pulses. Sits between the VGA-timed playfield and the seven-segment score display.

Parameters:
LIVES, 3, balls per game; legal range 1..3.
SERVE_FRAMES, 60, frame ticks of frozen ball before play starts; must be at least 1.
MISS_FRAMES, 90, frame ticks of pause after a miss before the next serve; must be at least 1.
SCORE_W, 16, width of the score and high-score counters.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  start button level, already synchronised and debounced
hit  in  1  one-cycle pulse on a paddle collision
miss  in  1  one-cycle pulse when the ball reaches the right boundary
ball_run  out  1  playfield may advance the ball
ball_load  out  1  one-cycle pulse: playfield reloads the ball to its serve position
score  out  SCORE_W  current game score
high_score  out  SCORE_W  best score since reset
lives  out  2  balls remaining
state  out  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4
game_over  out  1  high while in OVER

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered or decoded only from registered state.
- Reset values: state=IDLE, score=0, high_score=0, lives=LIVES, frame timer=0, start_d=0, ball_load=0. This gives ball_run=0 and game_over=0.
- Reset asserted mid-game returns everything to the reset values on the next clk edge. high_score is also cleared.
- Start detection: start_d is the registered copy of start. start_rise = start & ~start_d. A held button causes only one start.
- ball_run = (state==PLAY).
- game_over = (state==OVER).
- IDLE:
  - On start_rise: score<=0, lives<=LIVES, timer<=0, ball_load<=1, state<=SERVE.
- SERVE:
  - Each frame_tick increments the timer.
  - On a frame_tick with timer==SERVE_FRAMES-1: timer<=0, state<=PLAY.
- PLAY:
  - hit: score<=score+1. Saturates at all-ones and never wraps.
  - miss: lives<=lives-1 and timer<=0. If lives==1, state<=OVER; otherwise state<=MISS.
  - hit and miss in the same cycle: miss is processed, hit is dropped, score is unchanged.
- MISS:
  - Each frame_tick increments the timer.
  - On a frame_tick with timer==MISS_FRAMES-1: timer<=0, ball_load<=1, state<=SERVE.
- OVER:
  - On entry, in the same edge as the PLAY->OVER transition: if score>high_score then high_score<=score.
  - On start_rise: same actions as start from IDLE.
- ball_load is high for exactly the one cycle after the edge that entered SERVE. It defaults to 0 every other cycle.
- Ignored inputs:
  - hit and miss outside PLAY.
  - start_rise in SERVE, PLAY and MISS.
  - frame_tick in IDLE, PLAY and OVER (timer holds).
- Latency: an input pulse at edge N shows its effect on outputs after edge N, i.e. one cycle.
- Timer width is ceil(log2(max(SERVE_FRAMES, MISS_FRAMES))) bits, minimum 1. With SERVE_FRAMES=1 or MISS_FRAMES=1 the state leaves on the first frame_tick.
- lives never underflows; OVER is entered while lives goes 1->0. lives holds 0 in OVER until restart.
- score holds its final value in OVER for display.

Test Plan:
- Reset then start held high for 10 cycles (LIVES=3, SERVE_FRAMES=2) -> exactly one ball_load pulse; state=1; lives=3; score=0; state=2 after the 2nd frame_tick; ball_run=1.
- In PLAY: 5 hit pulses, then hit and miss in the same cycle -> score=5, lives=2, state=3, ball_run=0.
- In MISS (MISS_FRAMES=3): 3 frame_ticks -> ball_load pulse after the 3rd; state=1; timer restarts; next 2 frame_ticks give state=2.
- Three misses in a game with score=7 and high_score=0 -> state=4, game_over=1, lives=0, high_score=7. A hit pulse in OVER leaves score=7.
- Restart from OVER via start rising edge, then a game ending with score=4 -> high_score stays 7, score=4. A further game with score=9 -> high_score=9.
- reset pulse during PLAY with score=3 and high_score=9 -> next cycle state=0, score=0, high_score=0, lives=3, ball_load=0.
- SCORE_W=4 with 20 hits -> score saturates at 15.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve/play/miss/over state machine that drives the playfield
// ball controls and keeps score, lives and high-score bookkeeping.
module pong_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  output logic               ball_run,
  output logic               ball_load,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [1:0]         lives,
  output logic [2:0]         state,
  output logic               game_over
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int TW         = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_FRAMES - 1);
  localparam logic [TW-1:0] MISS_LAST  = TW'(MISS_FRAMES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [TW-1:0]      timer_q, timer_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic [SCORE_W-1:0] high_q, high_n;
  logic [1:0]         lives_q, lives_n;
  logic               load_q, load_n;
  logic               start_d;
  logic               start_rise;

  assign start_rise = start & ~start_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      score_q <= '0;
      high_q  <= '0;
      lives_q <= LIVES_INIT;
      load_q  <= 1'b0;
      start_d <= 1'b0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
      score_q <= score_n;
      high_q  <= high_n;
      lives_q <= lives_n;
      load_q  <= load_n;
      start_d <= start;
    end
  end

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_n = state_q;
    timer_n = timer_q;
    score_n = score_q;
    high_n  = high_q;
    lives_n = lives_q;
    load_n  = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          score_n = '0;
          lives_n = LIVES_INIT;
          timer_n = '0;
          load_n  = 1'b1;
          state_n = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (timer_q == SERVE_LAST) begin
            timer_n = '0;
            state_n = S_PLAY;
          end else begin
            timer_n = timer_q + TW'(1);
          end
        end
      end
      S_PLAY: begin
        // A simultaneous hit is dropped in favour of the miss.
        if (miss) begin
          lives_n = lives_q - 2'd1;
          timer_n = '0;
          if (lives_q == 2'd1) begin
            state_n = S_OVER;
            if (score_q > high_q) high_n = score_q;
          end else begin
            state_n = S_MISS;
          end
        end else if (hit && (score_q != '1)) begin
          score_n = score_q + SCORE_W'(1);
        end
      end
      S_MISS: begin
        if (frame_tick) begin
          if (timer_q == MISS_LAST) begin
            timer_n = '0;
            load_n  = 1'b1;
            state_n = S_SERVE;
          end else begin
            timer_n = timer_q + TW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign state      = state_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign lives      = lives_q;
  assign ball_load  = load_q;
  assign ball_run   = (state_q == S_PLAY);
  assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a vector table for the first game, then
// hand-written sequences for high-score tracking, mid-game reset and saturation.
module tb_pong_game_ctrl;

  localparam int SCORE_W = 4;

  logic               clk = 1'b0;
  logic               reset, frame_tick, start, hit, miss;
  logic               ball_run, ball_load, game_over;
  logic [SCORE_W-1:0] score, high_score;
  logic [1:0]         lives;
  logic [2:0]         state;

  int errors = 0;
  int checks = 0;

  pong_game_ctrl #(
    .LIVES(3), .SERVE_FRAMES(2), .MISS_FRAMES(3), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .hit(hit), .miss(miss), .ball_run(ball_run), .ball_load(ball_load),
    .score(score), .high_score(high_score), .lives(lives), .state(state),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, st, ft, h, m;
    int e_state, e_score, e_lives, e_load, e_high;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(bit rst, bit st, bit ft, bit h, bit m,
                              int es, int esc, int el, int eld, int eh);
    vec_t v;
    v.rst = rst; v.st = st; v.ft = ft; v.h = h; v.m = m;
    v.e_state = es; v.e_score = esc; v.e_lives = el; v.e_load = eld; v.e_high = eh;
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, and leave outputs settled for sampling.
  task automatic cycle(input bit rst, input bit st, input bit ft, input bit h, input bit m);
    reset = rst; start = st; frame_tick = ft; hit = h; miss = m;
    @(posedge clk);
    #1;
    reset = 1'b0; frame_tick = 1'b0; hit = 1'b0; miss = 1'b0;
  endtask

  // From a fresh SERVE: serve, score n_hits, then lose all three balls.
  task automatic play_game(input int n_hits);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < n_hits; i++) cycle(0, 0, 0, 1, 0);
    for (int b = 0; b < 3; b++) begin
      cycle(0, 0, 0, 0, 1);
      if (b < 2) begin
        for (int k = 0; k < 5; k++) cycle(0, 0, 1, 0, 0);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; frame_tick = 1'b0; hit = 1'b0; miss = 1'b0;

    //             rst st ft h  m   state score lives load high
    vecs[0]  = mk(1, 0, 0, 0, 0,   0, 0, 3, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0,   1, 0, 3, 1, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0,   1, 0, 3, 0, 0);
    vecs[3]  = mk(0, 1, 1, 0, 0,   1, 0, 3, 0, 0);
    vecs[4]  = mk(0, 1, 1, 0, 0,   2, 0, 3, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 0,   2, 0, 3, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0,   2, 1, 3, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 0,   2, 2, 3, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0,   2, 3, 3, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 0,   2, 4, 3, 0, 0);
    vecs[10] = mk(0, 0, 0, 1, 0,   2, 5, 3, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 1,   3, 5, 2, 0, 0);
    vecs[12] = mk(0, 1, 1, 1, 0,   3, 5, 2, 0, 0);
    vecs[13] = mk(0, 0, 1, 0, 0,   3, 5, 2, 0, 0);
    vecs[14] = mk(0, 0, 1, 0, 0,   1, 5, 2, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 0,   1, 5, 2, 0, 0);
    vecs[16] = mk(0, 0, 1, 0, 0,   1, 5, 2, 0, 0);
    vecs[17] = mk(0, 0, 1, 0, 0,   2, 5, 2, 0, 0);
    vecs[18] = mk(0, 0, 1, 1, 0,   2, 6, 2, 0, 0);
    vecs[19] = mk(0, 0, 0, 1, 0,   2, 7, 2, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 1,   3, 7, 1, 0, 0);
    vecs[21] = mk(0, 0, 1, 0, 0,   3, 7, 1, 0, 0);
    vecs[22] = mk(0, 0, 1, 0, 0,   3, 7, 1, 0, 0);
    vecs[23] = mk(0, 0, 1, 0, 0,   1, 7, 1, 1, 0);
    vecs[24] = mk(0, 0, 1, 0, 0,   1, 7, 1, 0, 0);
    vecs[25] = mk(0, 0, 1, 0, 0,   2, 7, 1, 0, 0);
    vecs[26] = mk(0, 0, 0, 0, 1,   4, 7, 0, 0, 7);
    vecs[27] = mk(0, 0, 1, 1, 0,   4, 7, 0, 0, 7);
    vecs[28] = mk(0, 1, 0, 0, 0,   1, 0, 3, 1, 7);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i].rst, vecs[i].st, vecs[i].ft, vecs[i].h, vecs[i].m);
      check($sformatf("v%0d state", i), int'(state), vecs[i].e_state);
      check($sformatf("v%0d score", i), int'(score), vecs[i].e_score);
      check($sformatf("v%0d lives", i), int'(lives), vecs[i].e_lives);
      check($sformatf("v%0d ball_load", i), int'(ball_load), vecs[i].e_load);
      check($sformatf("v%0d high_score", i), int'(high_score), vecs[i].e_high);
      check($sformatf("v%0d ball_run", i), int'(ball_run), int'(vecs[i].e_state == 2));
      check($sformatf("v%0d game_over", i), int'(game_over), int'(vecs[i].e_state == 4));
    end

    // Second game ends lower: high score must stay.
    cycle(0, 0, 0, 0, 0);
    play_game(4);
    check("g2 state", int'(state), 4);
    check("g2 score", int'(score), 4);
    check("g2 high_score", int'(high_score), 7);
    check("g2 lives", int'(lives), 0);

    // Third game beats it.
    cycle(0, 1, 0, 0, 0);
    check("g3 load", int'(ball_load), 1);
    cycle(0, 0, 0, 0, 0);
    play_game(9);
    check("g3 score", int'(score), 9);
    check("g3 high_score", int'(high_score), 9);
    check("g3 game_over", int'(game_over), 1);

    // Reset in the middle of play clears everything including high score.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    check("pre-reset state", int'(state), 2);
    check("pre-reset score", int'(score), 3);
    cycle(1, 0, 0, 0, 0);
    check("rst state", int'(state), 0);
    check("rst score", int'(score), 0);
    check("rst high_score", int'(high_score), 0);
    check("rst lives", int'(lives), 3);
    check("rst ball_load", int'(ball_load), 0);
    check("rst ball_run", int'(ball_run), 0);

    // Score saturation at all-ones of a 4-bit counter.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 0);
    check("sat score", int'(score), 15);
    check("sat state", int'(state), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
